// File: rtl/game_pkg.sv
`default_nettype none
// game_pkg: shared screen geometry, pool sizing and state encodings for the game datapath.
// rev 1.0
package game_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int POS_W = X_W + Y_W;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  localparam int MAX_PLAYER_BULLET = 4;
  localparam int BULLET_WIDTH      = 4;
  localparam int BULLET_HEIGHT     = 8;
  localparam int PLAYER_WIDTH      = 32;
  localparam int PLAYER_CENTER_Y   = 440;
  localparam int BULLET_SPEED      = 4;
  localparam int FIRE_COOLDOWN     = 8;

  // Off-screen parking spot; never overlaps anything the collision logic tests.
  localparam logic [X_W-1:0] PARK_X = 10'd700;
  localparam logic [Y_W-1:0] PARK_Y = 9'd490;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_e;

  typedef enum logic {
    FIRE_READY = 1'b0,
    FIRE_WAIT  = 1'b1
  } fire_state_e;

endpackage
`default_nettype wire

// File: rtl/player_bullet_slot.sv
`default_nettype none
// player_bullet_slot: one IDLE/FLYING bullet slot holding its own position.
// rev 1.0
module player_bullet_slot
  import game_pkg::*;
#(
  parameter int                 SPEED  = 4,
  parameter logic [X_W-1:0]     IDLE_X = 10'd700,
  parameter logic [Y_W-1:0]     IDLE_Y = 9'd490
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Spawn,
  input  logic [X_W-1:0]   i_SpawnX,
  input  logic [Y_W-1:0]   i_SpawnY,
  input  logic             i_Tick,
  input  logic             i_Hit,
  input  logic             i_Clear,
  output logic             o_Active,
  output logic [POS_W-1:0] o_Position
);

  localparam logic [Y_W-1:0] STEP = Y_W'(SPEED);

  slot_state_e    state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Priority: clear, then hit, then off-top retirement, then move.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (i_Clear) begin
      state_d = SLOT_IDLE;
      x_d     = IDLE_X;
      y_d     = IDLE_Y;
    end else if (state_q == SLOT_IDLE) begin
      if (i_Spawn) begin
        state_d = SLOT_FLYING;
        x_d     = i_SpawnX;
        y_d     = i_SpawnY;
      end
    end else if (i_Hit || (i_Tick && (y_q < STEP))) begin
      state_d = SLOT_IDLE;
      x_d     = IDLE_X;
      y_d     = IDLE_Y;
    end else if (i_Tick) begin
      y_d = y_q - STEP;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= SLOT_IDLE;
      x_q     <= IDLE_X;
      y_q     <= IDLE_Y;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign o_Active   = (state_q == SLOT_FLYING);
  assign o_Position = {x_q, y_q};

endmodule
`default_nettype wire

// File: rtl/player_bullet_manager.sv
`default_nettype none
// player_bullet_manager: player-bullet pool with fire latch, shot cooldown and slot allocation.
// rev 1.0
module player_bullet_manager #(
  parameter int MAX_PLAYER_BULLET = game_pkg::MAX_PLAYER_BULLET,
  parameter int BULLET_WIDTH      = game_pkg::BULLET_WIDTH,
  parameter int BULLET_HEIGHT     = game_pkg::BULLET_HEIGHT,
  parameter int PLAYER_WIDTH      = game_pkg::PLAYER_WIDTH,
  parameter int PLAYER_CENTER_Y   = game_pkg::PLAYER_CENTER_Y,
  parameter int BULLET_SPEED      = game_pkg::BULLET_SPEED,
  parameter int FIRE_COOLDOWN     = game_pkg::FIRE_COOLDOWN,
  parameter int PARK_X            = 700,
  parameter int PARK_Y            = 490
) (
  input  logic                                           i_Clk,
  input  logic                                           i_Rst_n,
  input  logic                                           i_Tick,
  input  logic                                           i_Clear,
  input  logic                                           i_Fire,
  input  logic [game_pkg::X_W-1:0]                       i_PlayerPosition,
  input  logic [MAX_PLAYER_BULLET-1:0]                   i_Collision,
  output logic [game_pkg::POS_W*MAX_PLAYER_BULLET-1:0]   o_BulletPosition,
  output logic [MAX_PLAYER_BULLET-1:0]                   o_BulletActive,
  output logic                                           o_FireAccepted,
  output logic                                           o_PoolFull
);

  import game_pkg::*;

  localparam int             CD_W     = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
  localparam logic [X_W-1:0] SPAWN_DX = X_W'(PLAYER_WIDTH / 2 - BULLET_WIDTH / 2);
  localparam logic [Y_W-1:0] SPAWN_Y  = Y_W'(PLAYER_CENTER_Y - BULLET_HEIGHT);

  logic [MAX_PLAYER_BULLET-1:0] active;
  logic [MAX_PLAYER_BULLET-1:0] spawn_sel;
  logic [MAX_PLAYER_BULLET-1:0] slot_spawn;
  logic                         has_free;
  logic                         accept;
  logic [X_W-1:0]               spawn_x;

  fire_state_e     fire_state_q, fire_state_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic            pending_q, pending_d;
  logic            fire_accepted_q, fire_accepted_d;

  // Lowest-index idle slot, taken from the registered state so a slot
  // retiring this cycle is only reusable on a later tick.
  always_comb begin
    spawn_sel = '0;
    has_free  = 1'b0;
    for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
      if (!active[k] && !has_free) begin
        spawn_sel[k] = 1'b1;
        has_free     = 1'b1;
      end
    end
  end

  // A zero count at a tick re-arms in that same tick, keeping shots FIRE_COOLDOWN ticks apart.
  assign accept = i_Tick & pending_q & has_free & ~i_Clear &
                  ((fire_state_q == FIRE_READY) | (cooldown_q == '0));
  assign slot_spawn = accept ? spawn_sel : '0;
  assign spawn_x    = i_PlayerPosition + SPAWN_DX;

  always_comb begin
    fire_state_d    = fire_state_q;
    cooldown_d      = cooldown_q;
    pending_d       = pending_q;
    fire_accepted_d = 1'b0;
    if (i_Clear) begin
      fire_state_d = FIRE_READY;
      cooldown_d   = '0;
      pending_d    = 1'b0;
    end else begin
      pending_d       = i_Fire | (pending_q & ~accept);
      fire_accepted_d = accept;
      if (accept) begin
        fire_state_d = FIRE_WAIT;
        cooldown_d   = CD_W'(FIRE_COOLDOWN - 1);
      end else if (i_Tick && (fire_state_q == FIRE_WAIT)) begin
        if (cooldown_q == '0) begin
          fire_state_d = FIRE_READY;
        end else begin
          cooldown_d = cooldown_q - CD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fire_state_q    <= FIRE_READY;
      cooldown_q      <= '0;
      pending_q       <= 1'b0;
      fire_accepted_q <= 1'b0;
    end else begin
      fire_state_q    <= fire_state_d;
      cooldown_q      <= cooldown_d;
      pending_q       <= pending_d;
      fire_accepted_q <= fire_accepted_d;
    end
  end

  generate
    for (genvar k = 0; k < MAX_PLAYER_BULLET; k++) begin : g_slot
      player_bullet_slot #(
        .SPEED  (BULLET_SPEED),
        .IDLE_X (X_W'(PARK_X)),
        .IDLE_Y (Y_W'(PARK_Y))
      ) u_slot (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Spawn    (slot_spawn[k]),
        .i_SpawnX   (spawn_x),
        .i_SpawnY   (SPAWN_Y),
        .i_Tick     (i_Tick),
        .i_Hit      (i_Collision[k]),
        .i_Clear    (i_Clear),
        .o_Active   (active[k]),
        .o_Position (o_BulletPosition[POS_W*k +: POS_W])
      );
    end
  endgenerate

  assign o_BulletActive = active;
  assign o_PoolFull     = &active;
  assign o_FireAccepted = fire_accepted_q;

endmodule
`default_nettype wire

// File: doc/player_bullet_manager.md
Name: player_bullet_manager

Overview:
- Owns the player-bullet pool: spawns, moves, and retires player bullets.
- Produces the player-bullet position vector that the collision logic consumes.
- Consumes the per-bullet collision flags that the collision logic returns.
- Sits between the player input/position logic and the collision/render stages. Advances once per frame tick.

Parameters:
- MAX_PLAYER_BULLET, 4, number of bullet slots
- BULLET_WIDTH, 4, bullet width in px
- BULLET_HEIGHT, 8, bullet height in px
- PLAYER_WIDTH, 32, player width in px
- PLAYER_CENTER_Y, 440, player top y; spawn reference
- BULLET_SPEED, 4, px moved upward per tick
- FIRE_COOLDOWN, 8, ticks between accepted shots
- PARK_X, 700, x of an inactive slot (off-screen, no wrap)
- PARK_Y, 490, y of an inactive slot

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Tick  in  1  one-cycle frame-advance strobe
- i_Clear  in  1  synchronous game restart; empties pool
- i_Fire  in  1  fire request pulse or level
- i_PlayerPosition  in  10  player x (left edge)
- i_Collision  in  MAX_PLAYER_BULLET  per-slot hit flag from collision logic
- o_BulletPosition  out  19*MAX_PLAYER_BULLET  per slot {x[9:0], y[8:0]}; slot k at bits [19k+18:19k]
- o_BulletActive  out  MAX_PLAYER_BULLET  slot in FLYING state
- o_FireAccepted  out  1  one-cycle pulse on spawn
- o_PoolFull  out  1  all slots active

Behaviour:
- Reset (async, i_Rst_n=0):
  - all slots IDLE, every position = {PARK_X, PARK_Y}
  - o_BulletActive=0, o_FireAccepted=0, o_PoolFull=0
  - fire pending=0, cooldown counter=0
- Release of reset is synchronous to i_Clk. A reset asserted mid-flight discards every bullet immediately.
- Per-slot FSM, IDLE/FLYING:
  - IDLE -> FLYING on spawn.
  - FLYING -> IDLE on a collision, on off-top retirement, or on i_Clear.
  - An IDLE slot always outputs {PARK_X, PARK_Y}, so it never collides.
- Collision:
  - i_Collision[k] while slot k is FLYING retires slot k at the next clock edge, regardless of i_Tick.
  - i_Collision[k] on an IDLE slot is ignored.
  - Collision beats move when both occur in the same cycle.
- Move, on i_Tick for each FLYING slot not being retired:
  - if y < BULLET_SPEED, retire to IDLE
  - otherwise y <= y - BULLET_SPEED; x is unchanged
- Fire request latch:
  - i_Fire=1 in any cycle sets pending.
  - pending is cleared only by an accepted shot or by i_Clear.
  - A shot requested while the pool is full is held until a slot frees.
- Fire FSM, READY/COOLDOWN:
  - On i_Tick in READY with pending=1 and at least one slot free (sampled before this cycle's retirements):
    - spawn into the lowest-index IDLE slot
    - x = i_PlayerPosition + PLAYER_WIDTH/2 - BULLET_WIDTH/2, 10-bit
    - y = PLAYER_CENTER_Y - BULLET_HEIGHT, 9-bit
    - o_FireAccepted=1 for that cycle; clear pending
    - load cooldown = FIRE_COOLDOWN - 1 and go to COOLDOWN
  - COOLDOWN decrements on each i_Tick and returns to READY when the counter is 0 at a tick.
  - Result: consecutive spawns are exactly FIRE_COOLDOWN ticks apart.
  - A newly spawned bullet does not move on its spawn tick.
  - A slot freed in the same cycle is not reused until a later tick.
- Latency:
  - position updates are visible the cycle after i_Tick
  - collision retirement is visible the cycle after the flag
- i_Clear is synchronous and has priority over everything:
  - all slots IDLE and parked
  - pending=0, cooldown=0, FSM READY, o_FireAccepted=0
- o_PoolFull = &o_BulletActive, registered along with the slot state.
- All arithmetic is modulo the field width. Spawn x needs no clamp: a player x at most 640-PLAYER_WIDTH keeps it on-screen.

Decomposition:
- Shared package game_pkg:
  - position widths (X_W=10, Y_W=9, POS_W=19)
  - screen size constants 640/480
  - BULLET_WIDTH/HEIGHT, PLAYER_WIDTH, PLAYER_CENTER_Y, MAX_PLAYER_BULLET
  - park coordinates
  - slot state encoding
- One sub-module, player_bullet_slot, instantiated MAX_PLAYER_BULLET times:
  - holds IDLE/FLYING state and the position
  - inputs: spawn, spawn position, tick, hit, clear
- The top level holds the fire latch, the cooldown FSM and the lowest-free-slot priority encoder.

Test Plan:
1. Reset, then i_Fire pulse, then i_Tick with i_PlayerPosition=100 -> slot0 FLYING at {114, 432}, o_FireAccepted=1 for 1 cycle; next tick -> slot0 y=428, slot1 still {700, 490}.
2. i_Fire held high for 40 ticks -> spawns on ticks 1, 9, 17, 25, each in the next free slot; o_PoolFull=1 after the 4th spawn; further requests held pending.
3. Slot2 FLYING with i_Collision=4'b0100 in the same cycle as i_Tick -> slot2 IDLE, parked {700, 490}, no move applied; other slots move by 4.
4. Pool full and pending; slot1 hit; next eligible tick -> new bullet lands in slot1, not slot0/2/3.
5. Single bullet left to fly -> at y=4 the tick gives y=0, the next tick retires it; o_BulletActive drops and the slot is parked.
6. Mid-flight i_Clear=1 for 1 cycle -> all slots parked, pending cleared, next i_Fire plus tick spawns immediately with no cooldown. Repeat with async i_Rst_n low mid-cycle -> outputs reset without waiting for a clock edge.
